// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory access stage
package mem_stage_pkg;

    // Access FSM: IDLE accepts new instructions, WAIT holds one data-memory access open
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Default number of WAIT cycles before an unacknowledged access is aborted
    localparam int TIMEOUT_DEFAULT = 16;

    // Control values written into MEM/WB when a bubble is inserted
    localparam logic BUBBLE_REG_WRITE  = 1'b0;
    localparam logic BUBBLE_MEM_TO_REG = 1'b0;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load and bubble controls
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears every field)
//   load_i            capture all fields from the *_i inputs
//   bubble_i          clear the control bits, keep the data fields (wins over load_i)
//   *_i / *_o         read data, ALU result, destination register, regWrite, memToReg
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] read_data_i,
    input  logic [31:0] alu_result_i,
    input  logic [4:0]  write_reg_i,
    input  logic        reg_write_i,
    input  logic        mem_to_reg_i,
    output logic [31:0] read_data_o,
    output logic [31:0] alu_result_o,
    output logic [4:0]  write_reg_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o
);

    logic [31:0] read_data_q;
    logic [31:0] alu_result_q;
    logic [4:0]  write_reg_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (bubble_i) begin
            // Only the control bits are squashed; stale data is harmless without regWrite
            reg_write_q  <= BUBBLE_REG_WRITE;
            mem_to_reg_q <= BUBBLE_MEM_TO_REG;
        end else if (load_i) begin
            read_data_q  <= read_data_i;
            alu_result_q <= alu_result_i;
            write_reg_q  <= write_reg_i;
            reg_write_q  <= reg_write_i;
            mem_to_reg_q <= mem_to_reg_i;
        end
    end

    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;
    assign write_reg_o  = write_reg_q;
    assign reg_write_o  = reg_write_q;
    assign mem_to_reg_o = mem_to_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: branch resolve, data-memory access FSM, MEM/WB
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pcAdded, zeroFlag, branch     branch inputs -> pcSrc, branchTarget (combinational)
//   aluResult, writeData, writeReg, memWrite, memRead, regWrite, memToReg   EX/MEM fields
//   memReq, memWe, memAddr, memWdata, memRdata, memAck                      data-memory port
//   stall                         holds EX/MEM and upstream while an access is pending
//   out*                          MEM/WB fields
//   alignErr, busErr              one-cycle error pulses (misaligned access, access timeout)
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcAdded,
    input  logic [31:0] zeroFlag,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeData,
    input  logic [4:0]  writeReg,
    input  logic        branch,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic        regWrite,
    input  logic        memToReg,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        stall,
    output logic        pcSrc,
    output logic [31:0] branchTarget,
    output logic [31:0] outReadData,
    output logic [31:0] outAluResult,
    output logic [4:0]  outWriteReg,
    output logic        outRegWrite,
    output logic        outMemToReg,
    output logic        alignErr,
    output logic        busErr
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               align_err_q, align_err_d;
    logic               bus_err_q, bus_err_d;

    logic               access;
    logic               aligned;
    logic               stall_c;
    logic               wb_bubble;
    logic [31:0]        wb_rdata;

    assign pcSrc        = branch & (|zeroFlag);
    assign branchTarget = pcAdded;

    assign access  = memRead | memWrite;
    assign aligned = (aluResult[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        stall_c     = 1'b0;
        wb_bubble   = 1'b0;
        wb_rdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (access && aligned) begin
                    // Request signals are registered on entry so they stay stable for the
                    // whole WAIT phase; a simultaneous read is dropped in favour of the write.
                    stall_c   = 1'b1;
                    wb_bubble = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = memWrite;
                    addr_d    = aluResult;
                    wdata_d   = writeData;
                end else if (access) begin
                    wb_bubble   = 1'b1;
                    align_err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (memAck) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    wb_rdata = we_q ? 32'd0 : memRdata;
                end else if (cnt_q == CNT_LAST) begin
                    // Release stall on the last cycle so the aborted instruction retires
                    // as a bubble instead of being replayed.
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    wb_bubble = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    stall_c   = 1'b1;
                    wb_bubble = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stall    = stall_c;
    assign memReq   = req_q;
    assign memWe    = we_q;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign alignErr = align_err_q;
    assign busErr   = bus_err_q;

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .load_i       (!wb_bubble),
        .bubble_i     (wb_bubble),
        .read_data_i  (wb_rdata),
        .alu_result_i (aluResult),
        .write_reg_i  (writeReg),
        .reg_write_i  (regWrite),
        .mem_to_reg_i (memToReg),
        .read_data_o  (outReadData),
        .alu_result_o (outAluResult),
        .write_reg_o  (outWriteReg),
        .reg_write_o  (outRegWrite),
        .mem_to_reg_o (outMemToReg)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcAdded, zeroFlag, aluResult, writeData, memRdata;
    logic [4:0]  writeReg;
    logic        branch, memWrite, memRead, regWrite, memToReg, memAck;
    logic        memReq, memWe, stall, pcSrc, outRegWrite, outMemToReg, alignErr, busErr;
    logic [31:0] memAddr, memWdata, branchTarget, outReadData, outAluResult;
    logic [4:0]  outWriteReg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the MEM/WB data fields (what the stage should currently hold)
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_wreg;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pcAdded(pcAdded), .zeroFlag(zeroFlag), .aluResult(aluResult),
        .writeData(writeData), .writeReg(writeReg), .branch(branch), .memWrite(memWrite),
        .memRead(memRead), .regWrite(regWrite), .memToReg(memToReg), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata),
        .memAck(memAck), .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
        .outReadData(outReadData), .outAluResult(outAluResult), .outWriteReg(outWriteReg),
        .outRegWrite(outRegWrite), .outMemToReg(outMemToReg), .alignErr(alignErr),
        .busErr(busErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b0; memToReg = 1'b0;
        branch = 1'b0; memAck = 1'b0;
    endtask

    // One edge with a non-memory instruction presented: its fields pass straight to MEM/WB
    task automatic nop_edge();
        tick();
        m_rd = 32'd0; m_alu = aluResult; m_wreg = writeReg;
    endtask

    // Runs one instruction from IDLE; k is the WAIT cycle on which memAck arrives
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [4:0] wreg, input logic rw, input logic m2r,
                             input int k);
        logic active, al;
        nop_edge();
        active = rd | wr;
        al = (addr[1:0] == 2'b00);
        memRead = rd; memWrite = wr; aluResult = addr; writeData = wdata; writeReg = wreg;
        regWrite = rw; memToReg = m2r; memRdata = rdata; memAck = 1'b0;
        #3;
        n_checks++; if (stall !== (active && al)) begin n_fail++; $display("FAIL acc_stall0 got=%b exp=%b", stall, active && al); end
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL acc_req0 got=%b exp=0", memReq); end
        if (active && al) begin
            for (int j = 1; j <= k; j++) begin
                tick();
                memAck = (j == k);
                #3;
                n_checks++; if (memReq !== 1'b1) begin n_fail++; $display("FAIL wait_req c%0d got=%b exp=1", j, memReq); end
                n_checks++; if (memWe !== wr) begin n_fail++; $display("FAIL wait_we c%0d got=%b exp=%b", j, memWe, wr); end
                n_checks++; if (memAddr !== addr) begin n_fail++; $display("FAIL wait_addr c%0d got=%h exp=%h", j, memAddr, addr); end
                n_checks++; if (memWdata !== wdata) begin n_fail++; $display("FAIL wait_wdata c%0d got=%h exp=%h", j, memWdata, wdata); end
                n_checks++; if (stall !== (j < k)) begin n_fail++; $display("FAIL wait_stall c%0d got=%b exp=%b", j, stall, j < k); end
            end
            tick();
            set_nop();
            m_rd = wr ? 32'd0 : rdata; m_alu = addr; m_wreg = wreg;
            #3;
            n_checks++; if (outRegWrite !== rw) begin n_fail++; $display("FAIL done_regwrite got=%b exp=%b", outRegWrite, rw); end
            n_checks++; if (outMemToReg !== m2r) begin n_fail++; $display("FAIL done_memtoreg got=%b exp=%b", outMemToReg, m2r); end
            n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL done_req got=%b exp=0", memReq); end
        end else if (active) begin
            tick();
            set_nop();
            #3;
            n_checks++; if (alignErr !== 1'b1) begin n_fail++; $display("FAIL mis_alignerr got=%b exp=1", alignErr); end
            n_checks++; if (outRegWrite !== 1'b0 || outMemToReg !== 1'b0) begin n_fail++; $display("FAIL mis_bubble got=%b%b exp=00", outRegWrite, outMemToReg); end
            n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL mis_req got=%b exp=0", memReq); end
        end else begin
            tick();
            set_nop();
            m_rd = 32'd0; m_alu = addr; m_wreg = wreg;
            #3;
            n_checks++; if (outRegWrite !== rw || outMemToReg !== m2r) begin n_fail++; $display("FAIL pass_ctrl got=%b%b exp=%b%b", outRegWrite, outMemToReg, rw, m2r); end
        end
        n_checks++; if (outReadData !== m_rd) begin n_fail++; $display("FAIL out_rdata got=%h exp=%h", outReadData, m_rd); end
        n_checks++; if (outAluResult !== m_alu) begin n_fail++; $display("FAIL out_alu got=%h exp=%h", outAluResult, m_alu); end
        n_checks++; if (outWriteReg !== m_wreg) begin n_fail++; $display("FAIL out_wreg got=%0d exp=%0d", outWriteReg, m_wreg); end
        n_checks++; if (busErr !== 1'b0) begin n_fail++; $display("FAIL acc_buserr got=%b exp=0", busErr); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        pcAdded = '0; zeroFlag = '0; aluResult = '0; writeData = '0; writeReg = '0; memRdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({memReq, memWe, memAddr, memWdata} !== '0) begin n_fail++; $display("FAIL rst_mem got=%b%b %h %h exp=0", memReq, memWe, memAddr, memWdata); end
        n_checks++; if ({outReadData, outAluResult, outWriteReg, outRegWrite, outMemToReg} !== '0) begin n_fail++; $display("FAIL rst_wb got=%h %h %0d %b%b exp=0", outReadData, outAluResult, outWriteReg, outRegWrite, outMemToReg); end
        n_checks++; if (alignErr !== 1'b0 || busErr !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%b%b%b exp=000", alignErr, busErr, stall); end
        rst = 1'b0;
        m_rd = '0; m_alu = '0; m_wreg = '0;
    endtask

    task automatic test_branch();
        logic        b;
        logic [31:0] z, p;
        nop_edge();
        branch = 1'b1; zeroFlag = 32'd0; pcAdded = 32'h40;
        #3;
        n_checks++; if (pcSrc !== 1'b0) begin n_fail++; $display("FAIL br_notaken got=%b exp=0", pcSrc); end
        zeroFlag = 32'd1;
        #1;
        n_checks++; if (pcSrc !== 1'b1 || branchTarget !== 32'h40 || stall !== 1'b0) begin n_fail++; $display("FAIL br_taken got=%b %h %b exp=1 40 0", pcSrc, branchTarget, stall); end
        for (int i = 0; i < 10; i++) begin
            nop_edge();
            b = 1'($urandom_range(0, 1));
            z = ($urandom_range(0, 1) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
            p = $urandom;
            branch = b; zeroFlag = z; pcAdded = p;
            #3;
            n_checks++; if (pcSrc !== (b && (z != 0)) || branchTarget !== p) begin n_fail++; $display("FAIL br_rand%0d got=%b %h exp=%b %h", i, pcSrc, branchTarget, b && (z != 0), p); end
        end
        branch = 1'b0;
    endtask

    task automatic test_load();
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 1'b1, 3);
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 32'h104, 32'h55, 32'hCAFEF00D, 5'd7, 1'b0, 1'b0, 1);
        do_access(1'b1, 1'b1, 32'h200, 32'h77, 32'h12345678, 5'd9, 1'b1, 1'b0, 2);
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 1'b0, 32'h102, 32'h0, 32'h11111111, 5'd3, 1'b1, 1'b1, 1);
        nop_edge();
        #3;
        n_checks++; if (alignErr !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_once got=%b exp=0", alignErr); end
    endtask

    task automatic test_timeout();
        nop_edge();
        memRead = 1'b1; aluResult = 32'h300; writeReg = 5'd4; regWrite = 1'b1; memToReg = 1'b1;
        #3;
        for (int i = 1; i <= TO; i++) begin
            tick();
            #3;
            n_checks++; if (memReq !== 1'b1 || stall !== (i < TO)) begin n_fail++; $display("FAIL to_wait c%0d got=%b%b exp=1%b", i, memReq, stall, i < TO); end
        end
        tick();
        set_nop();
        #3;
        n_checks++; if (busErr !== 1'b1 || memReq !== 1'b0) begin n_fail++; $display("FAIL to_abort got=%b%b exp=10", busErr, memReq); end
        n_checks++; if (outRegWrite !== 1'b0 || outReadData !== m_rd) begin n_fail++; $display("FAIL to_bubble got=%b %h exp=0 %h", outRegWrite, outReadData, m_rd); end
        memAck = 1'b1;
        nop_edge();
        #3;
        n_checks++; if (busErr !== 1'b0 || memReq !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL to_late_ack got=%b%b%b exp=000", busErr, memReq, stall); end
        memAck = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        nop_edge();
        memRead = 1'b1; aluResult = 32'h400; writeReg = 5'd6; regWrite = 1'b1;
        tick();
        #3;
        n_checks++; if (memReq !== 1'b1) begin n_fail++; $display("FAIL rw_req got=%b exp=1", memReq); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({memReq, memWe, memAddr, memWdata} !== '0) begin n_fail++; $display("FAIL rw_async got=%b%b %h %h exp=0", memReq, memWe, memAddr, memWdata); end
        n_checks++; if ({outReadData, outAluResult, outWriteReg, outRegWrite, outMemToReg, alignErr, busErr} !== '0) begin n_fail++; $display("FAIL rw_outs got=%h %h %0d exp=0", outReadData, outAluResult, outWriteReg); end
        set_nop();
        memAck = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_rd = '0; m_alu = '0; m_wreg = '0;
        #3;
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL rw_ack_ignored got=%b exp=0", memReq); end
        memAck = 1'b0;
        do_access(1'b1, 1'b0, 32'h500, 32'h0, 32'hA5A5A5A5, 5'd8, 1'b1, 1'b1, 2);
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] addr;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 4);
            addr = {$urandom, 2'b00} & 32'h0000FFFC;
            if (kind == 4) addr = addr | 32'($urandom_range(1, 3));
            do_access(kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 3, addr,
                      $urandom, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 5));
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
